// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel divider, scan counters, sync/blank, start/stop FSM.
// Define VGA_TIMING_FRAME_CNT_EN to build the 16-bit completed-frame counter.
module vga_timing_gen #(
   parameter int unsigned H_DISP  = 640,
   parameter int unsigned H_FP    = 16,
   parameter int unsigned H_SYNC  = 96,
   parameter int unsigned H_BP    = 48,
   parameter int unsigned V_DISP  = 480,
   parameter int unsigned V_FP    = 10,
   parameter int unsigned V_SYNC  = 2,
   parameter int unsigned V_BP    = 33,
   parameter bit          HS_POL  = 1'b0,
   parameter bit          VS_POL  = 1'b0,
   parameter int unsigned CLK_DIV = 2,
   parameter int unsigned CNT_W   = 11
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   output logic             running,
   output logic             p_tick,
   output logic             hsync,
   output logic             vsync,
   output logic             video_on,
   output logic [CNT_W-1:0] pixel_x,
   output logic [CNT_W-1:0] pixel_y,
   output logic             line_start,
   output logic             frame_start,
   output logic [15:0]      frame_cnt
);

   localparam int unsigned H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT = V_DISP + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);
   localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_DISP);
   localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_DISP);
   localparam logic [CNT_W-1:0] H_HS0  = CNT_W'(H_DISP + H_FP);
   localparam logic [CNT_W-1:0] H_HS1  = CNT_W'(H_DISP + H_FP + H_SYNC - 1);
   localparam logic [CNT_W-1:0] V_VS0  = CNT_W'(V_DISP + V_FP);
   localparam logic [CNT_W-1:0] V_VS1  = CNT_W'(V_DISP + V_FP + V_SYNC - 1);
   localparam logic [3:0]       DIV_LAST = 4'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_STOP_PEND
   } state_e;

   state_e           state_q, state_d;
   logic [3:0]       div_q, div_d;
   logic             tick_q, tick_d;
   logic [CNT_W-1:0] px_q, px_d;
   logic [CNT_W-1:0] py_q, py_d;
   logic [CNT_W-1:0] nx, ny;
   logic             hs_q, hs_d;
   logic             vs_q, vs_d;
   logic             vo_q, vo_d;
   logic             ls_q, ls_d;
   logic             fs_q, fs_d;
   logic             act_d;
   logic             eol, eof;

   assign eol = (px_q == H_LAST);
   assign eof = eol && (py_q == V_LAST);

   // tick_q is the registered image of (div_q == DIV_LAST), so p_tick is
   // aligned with the divider yet still forced low while reset is held.
   always_comb begin
      div_d  = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
      tick_d = (div_d == DIV_LAST);
   end

   always_comb begin
      nx = eol ? '0 : px_q + 1'b1;
      ny = py_q;
      if (eol) begin
         ny = (py_q == V_LAST) ? '0 : py_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      px_d    = px_q;
      py_d    = py_q;
      if (tick_q) begin
         case (state_q)
            S_IDLE: begin
               if (en) begin
                  state_d = S_RUN;
               end
               px_d = '0;
               py_d = '0;
            end
            S_RUN: begin
               px_d = nx;
               py_d = ny;
               if (!en) begin
                  state_d = eof ? S_IDLE : S_STOP_PEND;
               end
            end
            S_STOP_PEND: begin
               px_d = nx;
               py_d = ny;
               if (en) begin
                  state_d = S_RUN;
               end else if (eof) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
               px_d    = '0;
               py_d    = '0;
            end
         endcase
      end
   end

   // Decode from next-state values so every registered output names the same pixel.
   always_comb begin
      act_d = (state_d != S_IDLE);
      hs_d  = ~HS_POL;
      vs_d  = ~VS_POL;
      if (act_d && (px_d >= H_HS0) && (px_d <= H_HS1)) begin
         hs_d = HS_POL;
      end
      if (act_d && (py_d >= V_VS0) && (py_d <= V_VS1)) begin
         vs_d = VS_POL;
      end
      vo_d = act_d && (px_d < H_VIS) && (py_d < V_VIS);
      ls_d = tick_d && act_d && (px_d == '0);
      fs_d = ls_d && (py_d == '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         div_q   <= 4'd0;
         tick_q  <= 1'b0;
         px_q    <= '0;
         py_q    <= '0;
         hs_q    <= ~HS_POL;
         vs_q    <= ~VS_POL;
         vo_q    <= 1'b0;
         ls_q    <= 1'b0;
         fs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         tick_q  <= tick_d;
         px_q    <= px_d;
         py_q    <= py_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         vo_q    <= vo_d;
         ls_q    <= ls_d;
         fs_q    <= fs_d;
      end
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] fcnt_q;
   logic        fc_inc;

   assign fc_inc = tick_q && (state_q != S_IDLE) && eof;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fcnt_q <= 16'd0;
      end else if (fc_inc) begin
         fcnt_q <= fcnt_q + 16'd1;
      end
   end

   assign frame_cnt = fcnt_q;
`else
   assign frame_cnt = 16'd0;
`endif

   assign running     = (state_q != S_IDLE);
   assign p_tick      = tick_q;
   assign hsync       = hs_q;
   assign vsync       = vs_q;
   assign video_on    = vo_q;
   assign pixel_x     = px_q;
   assign pixel_y     = py_q;
   assign line_start  = ls_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small raster configs checked every clk
// against a pixel-index reference model, plus directed period/stop/reset checks.
module tb_vga_timing_gen;

   typedef struct {
      int cdiv;
      int hd, hf, hs, hb;
      int vd, vf, vs, vb;
      bit hp, vp;
   } cfg_t;

   typedef struct {
      int n;
      bit run;
      int pos;
      int fc;
   } st_t;

   typedef struct {
      logic [31:0] run, pt, hs, vs, vo, x, y, ls, fs, fc;
   } obs_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic en_a = 1'b0;
   logic en_b = 1'b0;

   logic run_a, pt_a, hs_a, vs_a, vo_a, ls_a, fs_a;
   logic [5:0] px_a, py_a;
   logic [15:0] fc_a;
   logic run_b, pt_b, hs_b, vs_b, vo_b, ls_b, fs_b;
   logic [3:0] px_b, py_b;
   logic [15:0] fc_b;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   cfg_t ca, cb;
   st_t  sa, sb;
   st_t  s0 = '{n: 0, run: 1'b0, pos: 0, fc: 0};

   always #5 clk = ~clk;

   vga_timing_gen #(
      .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b1), .CLK_DIV(3), .CNT_W(6)
   ) u_a (
      .clk(clk), .reset(reset), .en(en_a), .running(run_a),
      .p_tick(pt_a), .hsync(hs_a), .vsync(vs_a), .video_on(vo_a),
      .pixel_x(px_a), .pixel_y(py_a), .line_start(ls_a),
      .frame_start(fs_a), .frame_cnt(fc_a)
   );

   vga_timing_gen #(
      .H_DISP(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
      .V_DISP(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b0), .CLK_DIV(1), .CNT_W(4)
   ) u_b (
      .clk(clk), .reset(reset), .en(en_b), .running(run_b),
      .p_tick(pt_b), .hsync(hs_b), .vsync(vs_b), .video_on(vo_b),
      .pixel_x(px_b), .pixel_y(py_b), .line_start(ls_b),
      .frame_start(fs_b), .frame_cnt(fc_b)
   );

   function automatic int htot(cfg_t c);
      return c.hd + c.hf + c.hs + c.hb;
   endfunction

   function automatic int vtot(cfg_t c);
      return c.vd + c.vf + c.vs + c.vb;
   endfunction

   function automatic bit tick_of(cfg_t c, st_t s);
      return (s.n >= 1) && (s.n % c.cdiv == c.cdiv - 1);
   endfunction

   // Scan position is a single pixel index within the frame.
   function automatic st_t mstep(cfg_t c, st_t s, bit en);
      st_t r;
      int tot;
      r = s;
      tot = htot(c) * vtot(c);
      r.n = s.n + 1;
      if (tick_of(c, s)) begin
         if (!s.run) begin
            if (en) begin
               r.run = 1'b1;
               r.pos = 0;
            end
         end else begin
            if (s.pos == tot - 1) r.fc = (s.fc + 1) % 65536;
            if (s.pos == tot - 1 && !en) begin
               r.run = 1'b0;
               r.pos = 0;
            end else begin
               r.pos = (s.pos + 1) % tot;
            end
         end
      end
      return r;
   endfunction

   function automatic obs_t mout(cfg_t c, st_t s);
      obs_t o;
      int x, y;
      bit pt, hsa, vsa;
      x = s.pos % htot(c);
      y = s.pos / htot(c);
      pt = tick_of(c, s);
      hsa = s.run && x >= c.hd + c.hf && x < c.hd + c.hf + c.hs;
      vsa = s.run && y >= c.vd + c.vf && y < c.vd + c.vf + c.vs;
      o.run = 32'(s.run);
      o.pt = 32'(pt);
      o.hs = 32'(hsa ? c.hp : !c.hp);
      o.vs = 32'(vsa ? c.vp : !c.vp);
      o.vo = 32'(s.run && x < c.hd && y < c.vd);
      o.x = 32'(x);
      o.y = 32'(y);
      o.ls = 32'(pt && s.run && x == 0);
      o.fs = 32'(pt && s.run && x == 0 && y == 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
      o.fc = 32'(s.fc);
`else
      o.fc = 32'd0;
`endif
      return o;
   endfunction

   task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic cmp(string p, obs_t o, obs_t e);
      chk({p, "running"}, o.run, e.run);
      chk({p, "p_tick"}, o.pt, e.pt);
      chk({p, "hsync"}, o.hs, e.hs);
      chk({p, "vsync"}, o.vs, e.vs);
      chk({p, "video_on"}, o.vo, e.vo);
      chk({p, "pixel_x"}, o.x, e.x);
      chk({p, "pixel_y"}, o.y, e.y);
      chk({p, "line_start"}, o.ls, e.ls);
      chk({p, "frame_start"}, o.fs, e.fs);
      chk({p, "frame_cnt"}, o.fc, e.fc);
   endtask

   task automatic check_all();
      obs_t oa, ob;
      oa = '{run: 32'(run_a), pt: 32'(pt_a), hs: 32'(hs_a), vs: 32'(vs_a),
             vo: 32'(vo_a), x: 32'(px_a), y: 32'(py_a), ls: 32'(ls_a),
             fs: 32'(fs_a), fc: 32'(fc_a)};
      ob = '{run: 32'(run_b), pt: 32'(pt_b), hs: 32'(hs_b), vs: 32'(vs_b),
             vo: 32'(vo_b), x: 32'(px_b), y: 32'(py_b), ls: 32'(ls_b),
             fs: 32'(fs_b), fc: 32'(fc_b)};
      cmp("a.", oa, mout(ca, sa));
      cmp("b.", ob, mout(cb, sb));
   endtask

   task automatic step();
      @(posedge clk);
      if (!reset) begin
         sa = mstep(ca, sa, en_a);
         sb = mstep(cb, sb, en_b);
      end
      @(negedge clk);
      cyc++;
      check_all();
   endtask

   task automatic async_reset();
      #2 reset = 1'b1;
      sa = s0;
      sb = s0;
      #1;
      chk("rst.frame_cnt", 32'(fc_a), 32'd0);
      chk("rst.running", 32'(run_a), 32'd0);
      chk("rst.pixel_x", 32'(px_a), 32'd0);
      chk("rst.pixel_y", 32'(py_a), 32'd0);
      chk("rst.p_tick_b", 32'(pt_b), 32'd0);
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      int prev_fs, prev_ls, prev_fb, nfs, nptb, t0, px, py;
      bit found;
      ca = '{cdiv: 3, hd: 8, hf: 2, hs: 3, hb: 2, vd: 4, vf: 1, vs: 2, vb: 1,
             hp: 1'b0, vp: 1'b1};
      cb = '{cdiv: 1, hd: 4, hf: 1, hs: 1, hb: 1, vd: 2, vf: 1, vs: 1, vb: 1,
             hp: 1'b1, vp: 1'b0};
      sa = s0;
      sb = s0;

      // reset state, then idle with scanning disabled
      repeat (3) step();
      reset = 1'b0;
      repeat (10) step();

      // continuous scan: frame, line and tick periods
      en_a = 1'b1;
      en_b = 1'b1;
      prev_fs = -1;
      prev_ls = -1;
      prev_fb = -1;
      nfs = 0;
      nptb = 0;
      for (int i = 0; i < 1000; i++) begin
         step();
         if (pt_b) nptb++;
         if (fs_a) begin
            nfs++;
            if (prev_fs >= 0) chk("a.frame_period", 32'(cyc - prev_fs), 32'd360);
            prev_fs = cyc;
         end
         if (ls_a) begin
            if (prev_ls >= 0) chk("a.line_period", 32'(cyc - prev_ls), 32'd45);
            prev_ls = cyc;
         end
         if (fs_b) begin
            if (prev_fb >= 0) chk("b.frame_period", 32'(cyc - prev_fb), 32'd35);
            prev_fb = cyc;
         end
      end
      chk("a.frame_starts", 32'(nfs), 32'd3);
      chk("b.ptick_count", 32'(nptb), 32'd1000);

      // drop en on line 2: frame must finish before going idle
      for (int i = 0; i < 400 && !(sa.run && sa.pos / 15 == 2); i++) step();
      en_a = 1'b0;
      found = 1'b0;
      px = int'(px_a);
      py = int'(py_a);
      for (int i = 0; i < 500; i++) begin
         step();
         if (!run_a) begin
            found = 1'b1;
            break;
         end
         px = int'(px_a);
         py = int'(py_a);
      end
      chk("a.stop_seen", 32'(found), 32'd1);
      chk("a.stop_last_x", 32'(px), 32'd14);
      chk("a.stop_last_y", 32'(py), 32'd7);
      chk("a.idle_hsync", 32'(hs_a), 32'd1);
      chk("a.idle_vsync", 32'(vs_a), 32'd0);
      chk("a.idle_video", 32'(vo_a), 32'd0);
      repeat (20) step();

      // stop request withdrawn mid-frame: no gap between frames
      en_a = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 400; i++) begin
         step();
         if (fs_a) begin
            found = 1'b1;
            break;
         end
      end
      chk("a.restart_fs", 32'(found), 32'd1);
      t0 = cyc;
      repeat (100) step();
      en_a = 1'b0;
      repeat (30) step();
      en_a = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 600; i++) begin
         step();
         if (fs_a) begin
            found = 1'b1;
            break;
         end
      end
      chk("a.resume_fs", 32'(found), 32'd1);
      chk("a.resume_gap", 32'(cyc - t0), 32'd360);

      // random enable toggling
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) en_a = ~en_a;
         if ($urandom_range(0, 19) == 0) en_b = ~en_b;
         step();
      end

      // three frames, then an asynchronous reset mid-frame
      async_reset();
      en_a = 1'b1;
      for (int i = 0; i < 1500 && sa.fc < 3; i++) step();
      repeat (60) step();
`ifdef VGA_TIMING_FRAME_CNT_EN
      chk("a.frame_cnt_3", 32'(fc_a), 32'd3);
`else
      chk("a.frame_cnt_tied", 32'(fc_a), 32'd0);
`endif
      async_reset();
      repeat (20) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
